// File: rtl/dmem_arbiter.sv
// Two-port (core/debug) arbiter and byte/half/word access sequencer for a single-ported word memory.
// Optional MISALIGN_TRAP_EN: core accesses that cross a word boundary complete with an error instead.
module dmem_arbiter #(
    parameter int MEM_WORDS = 16000,
    parameter int MAW       = 14
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           c_req,
    output logic           c_ready,
    input  logic           c_we,
    input  logic [1:0]     c_size,
    input  logic           c_unsigned,
    input  logic [31:0]    c_addr,
    input  logic [31:0]    c_wdata,
    output logic           c_rvalid,
    output logic [31:0]    c_rdata,
    output logic           c_err,
    input  logic           d_req,
    output logic           d_ready,
    input  logic           d_we,
    input  logic [31:0]    d_addr,
    input  logic [31:0]    d_wdata,
    output logic           d_rvalid,
    output logic [31:0]    d_rdata,
    output logic           d_err,
    output logic           m_en,
    output logic           m_we,
    output logic [3:0]     m_wstrb,
    output logic [MAW-1:0] m_addr,
    output logic [31:0]    m_wdata,
    input  logic [31:0]    m_rdata
);
    typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, WAIT, ERR} state_t;
    state_t state, state_nx;

    logic           last_grant;  // 1 = debug port won the last accept
    logic           r_port, r_we, r_uns, r_split;
    logic [1:0]     r_size, r_off;
    logic [MAW-1:0] r_word;
    logic [31:0]    r_wdata, lo_q;

    logic        gnt_c, gnt_d, accept, a_we, a_uns, a_split, a_err;
    logic [1:0]  a_size;
    logic [31:0] a_addr, a_wdata, a_word;

    assign gnt_c   = c_req & (~d_req | last_grant);
    assign gnt_d   = d_req & ~gnt_c;
    assign c_ready = (state == IDLE) & gnt_c;
    assign d_ready = (state == IDLE) & gnt_d;
    assign accept  = c_ready | d_ready;

    assign a_we    = gnt_c ? c_we : d_we;
    assign a_size  = gnt_c ? c_size : 2'd2;
    assign a_uns   = gnt_c & c_unsigned;
    assign a_addr  = gnt_c ? c_addr : (d_addr & ~32'd3);
    assign a_wdata = gnt_c ? c_wdata : d_wdata;
    assign a_word  = {2'b00, a_addr[31:2]};
    assign a_split = (a_size == 2'd1 && a_addr[1:0] == 2'd3) ||
                     (a_size == 2'd2 && a_addr[1:0] != 2'd0);

    // Range check covers the second word of a split access, so no beat is ever issued for it.
    always_comb begin
        a_err = (a_size == 2'd3) || (a_word >= 32'(MEM_WORDS)) ||
                (a_split && (a_word + 32'd1 >= 32'(MEM_WORDS)));
`ifdef MISALIGN_TRAP_EN
        if (gnt_c && a_split) a_err = 1'b1;
`endif
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = a_err ? ERR : BEAT0;
            BEAT0:   state_nx = r_split ? BEAT1 : (r_we ? IDLE : WAIT);
            BEAT1:   state_nx = r_we ? IDLE : WAIT;
            WAIT:    state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Memory beat formatting: the 64-bit lane image spans words A (low) and A+1 (high).
    logic [63:0] st_wide;
    logic [7:0]  strb_wide;
    logic [3:0]  sz_mask;
    logic        beat, hi_beat;

    always_comb begin
        sz_mask   = (r_size == 2'd0) ? 4'h1 : (r_size == 2'd1) ? 4'h3 : 4'hF;
        st_wide   = {32'b0, r_wdata} << {r_off, 3'b000};
        strb_wide = {4'b0, sz_mask} << r_off;
        beat      = (state == BEAT0) || (state == BEAT1);
        hi_beat   = (state == BEAT1);
        m_en      = beat;
        m_we      = beat & r_we;
        m_addr    = beat ? (hi_beat ? r_word + 1'b1 : r_word) : '0;
        m_wstrb   = (beat & r_we) ? (hi_beat ? strb_wide[7:4] : strb_wide[3:0]) : 4'h0;
        m_wdata   = (beat & r_we) ? (hi_beat ? st_wide[63:32] : st_wide[31:0]) : 32'h0;
    end

    // Load formatting happens in WAIT, where m_rdata holds the last beat's word.
    logic [31:0] ld_lo, ld_hi, raw, fmt, rsp_data;
    logic        done, rsp_err;

    always_comb begin
        ld_lo = r_split ? lo_q : m_rdata;
        ld_hi = r_split ? m_rdata : 32'h0;
        raw   = 32'({ld_hi, ld_lo} >> {r_off, 3'b000});
        case (r_size)
            2'd0:    fmt = {{24{~r_uns & raw[7]}}, raw[7:0]};
            2'd1:    fmt = {{16{~r_uns & raw[15]}}, raw[15:0]};
            default: fmt = raw;
        endcase
        done     = (state == BEAT0 && r_we && !r_split) || (state == BEAT1 && r_we) ||
                   (state == WAIT) || (state == ERR);
        rsp_err  = (state == ERR);
        rsp_data = (state == WAIT) ? fmt : 32'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            r_port     <= 1'b0;
            r_we       <= 1'b0;
            r_uns      <= 1'b0;
            r_split    <= 1'b0;
            r_size     <= 2'd0;
            r_off      <= 2'd0;
            r_word     <= '0;
            r_wdata    <= 32'h0;
            lo_q       <= 32'h0;
            c_rvalid   <= 1'b0;
            c_err      <= 1'b0;
            c_rdata    <= 32'h0;
            d_rvalid   <= 1'b0;
            d_err      <= 1'b0;
            d_rdata    <= 32'h0;
        end else begin
            state <= state_nx;
            if (accept) begin
                last_grant <= gnt_d;
                r_port     <= gnt_d;
                r_we       <= a_we;
                r_uns      <= a_uns;
                r_split    <= a_split;
                r_size     <= a_size;
                r_off      <= a_addr[1:0];
                r_word     <= a_addr[MAW+1:2];
                r_wdata    <= a_wdata;
            end
            if (state == BEAT1) lo_q <= m_rdata;
            c_rvalid <= done & ~r_port;
            c_err    <= done & ~r_port & rsp_err;
            c_rdata  <= (done & ~r_port) ? rsp_data : 32'h0;
            d_rvalid <= done & r_port;
            d_err    <= done & r_port & rsp_err;
            d_rdata  <= (done & r_port) ? rsp_data : 32'h0;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: byte-array reference model predicts data, error and latency.
module tb_dmem_arbiter;
    localparam int MEM_WORDS = 16000;
    localparam int MAW = 14;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic c_req = 0, c_ready, c_we = 0, c_unsigned = 0, c_rvalid, c_err;
    logic [1:0] c_size = 0;
    logic [31:0] c_addr = 0, c_wdata = 0, c_rdata;
    logic d_req = 0, d_ready, d_we = 0, d_rvalid, d_err;
    logic [31:0] d_addr = 0, d_wdata = 0, d_rdata;
    logic m_en, m_we;
    logic [3:0] m_wstrb;
    logic [MAW-1:0] m_addr;
    logic [31:0] m_wdata, m_rdata;

    dmem_arbiter #(.MEM_WORDS(MEM_WORDS), .MAW(MAW)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_ready(c_ready), .c_we(c_we), .c_size(c_size), .c_unsigned(c_unsigned),
        .c_addr(c_addr), .c_wdata(c_wdata), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
        .d_req(d_req), .d_ready(d_ready), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .m_en(m_en), .m_we(m_we), .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Physical memory behind the DUT and the byte-level reference image.
    logic [31:0] dm [0:MEM_WORDS-1];
    logic [7:0]  refb [0:4*MEM_WORDS+255];

    always @(posedge clk) begin
        if (m_en && int'(m_addr) < MEM_WORDS) begin
            if (m_we) begin
                for (int b = 0; b < 4; b++)
                    if (m_wstrb[b]) dm[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
            end else begin
                m_rdata <= dm[m_addr];
            end
        end
    end

    int beat_n = 0;
    logic [31:0] bq_addr [$], bq_strb [$], bq_data [$];
    always @(posedge clk) begin
        if (m_en) begin
            beat_n <= beat_n + 1;
            bq_addr.push_back(32'(m_addr));
            bq_strb.push_back({28'b0, m_wstrb});
            bq_data.push_back(m_wdata);
        end
    end

    bit rec_en = 0;
    int gseq [$];
    logic [31:0] last_d_rdata = 0;
    always @(negedge clk) begin
        if (rec_en) begin
            if (c_ready) gseq.push_back(0);
            else if (d_ready) gseq.push_back(1);
            if (d_rvalid) last_d_rdata = d_rdata;
        end
    end

    function automatic logic [31:0] ref_word(input int w);
        return {refb[4*w+3], refb[4*w+2], refb[4*w+1], refb[4*w]};
    endfunction

    // One transaction on one port; expectations come straight from the access rules.
    task automatic txn(input bit port, input bit we, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
        logic [1:0] sz;
        logic [31:0] a, v, exp_d;
        int nb, word, lat, cnt, exp_beats;
        bit split, err;
        sz = port ? 2'd2 : size;
        a = port ? (addr & ~32'd3) : addr;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        word = int'(a >> 2);
        split = (sz != 2'd3) && (int'(a % 4) + nb > 4);
        err = (sz == 2'd3) || word >= MEM_WORDS || (split && word + 1 >= MEM_WORDS) ||
              (TRAP && !port && split);
        lat = err ? 2 : we ? (split ? 3 : 2) : (split ? 4 : 3);
        exp_beats = err ? 0 : split ? 2 : 1;
        exp_d = 32'h0;
        if (!err && !we) begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v = v | (32'(refb[int'(a) + i]) << (8 * i));
            if (!uns && nb == 1 && v[7]) v = v | 32'hFFFF_FF00;
            if (!uns && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
            exp_d = v;
        end
        if (!err && we)
            for (int i = 0; i < nb; i++) refb[int'(a) + i] = wdata[8*i +: 8];

        if (port) begin
            d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            c_req = 1; c_we = we; c_size = size; c_unsigned = uns; c_addr = addr; c_wdata = wdata;
        end
        beat_n = 0;
        bq_addr.delete(); bq_strb.delete(); bq_data.delete();
        #1;
        chk(port ? "d_ready" : "c_ready", {31'b0, port ? d_ready : c_ready}, 32'd1);
        @(posedge clk); #1;
        c_req = 0; d_req = 0;
        cnt = 1;
        while (!(port ? d_rvalid : c_rvalid) && cnt < 8) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("latency", 32'(cnt), 32'(lat));
        chk("err", {31'b0, port ? d_err : c_err}, {31'b0, err});
        chk("rdata", port ? d_rdata : c_rdata, exp_d);
        chk("other_rvalid", {31'b0, port ? c_rvalid : d_rvalid}, 32'd0);
        chk("beats", 32'(beat_n), 32'(exp_beats));
    endtask

    logic [31:0] ra;
    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) begin
            dm[i] = $urandom;
            for (int b = 0; b < 4; b++) refb[4*i + b] = dm[i][8*b +: 8];
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_c_rvalid", {31'b0, c_rvalid}, 32'd0);
        chk("rst_d_rvalid", {31'b0, d_rvalid}, 32'd0);
        chk("rst_c_rdata", c_rdata, 32'd0);
        chk("rst_m_en", {31'b0, m_en}, 32'd0);
        chk("rst_m_wstrb", {28'b0, m_wstrb}, 32'd0);
        rst_n = 1;
        @(posedge clk); #1;

        // Store/load round trip and sub-word loads.
        txn(0, 1, 2, 0, 32'h10, 32'hDEAD_BEEF);
        chk("sw_beat_addr", bq_addr.size() > 0 ? bq_addr[0] : 32'hX, 32'd4);
        chk("sw_beat_strb", bq_strb.size() > 0 ? bq_strb[0] : 32'hX, 32'hF);
        txn(0, 0, 2, 0, 32'h10, 0);
        txn(0, 1, 2, 0, 32'h10, 32'h8070_6050);
        txn(0, 0, 0, 0, 32'h13, 0);
        txn(0, 0, 0, 1, 32'h13, 0);
        txn(0, 0, 1, 0, 32'h12, 0);

        // Split half store and its load back.
        txn(0, 1, 1, 0, 32'h13, 32'h0000_ABCD);
        if (!TRAP && bq_addr.size() == 2) begin
            chk("sh_b0_addr", bq_addr[0], 32'd4);
            chk("sh_b0_strb", bq_strb[0], 32'h8);
            chk("sh_b0_data", bq_data[0], 32'hCD00_0000);
            chk("sh_b1_addr", bq_addr[1], 32'd5);
            chk("sh_b1_strb", bq_strb[1], 32'h1);
            chk("sh_b1_data", bq_data[1], 32'h0000_00AB);
        end
        txn(0, 0, 1, 1, 32'h13, 0);

        // Range and reserved-size errors.
        txn(0, 0, 2, 0, 32'(4 * MEM_WORDS - 2), 0);
        txn(0, 0, 3, 0, 32'h20, 0);
        txn(1, 1, 2, 0, 32'h23, 32'h1357_9BDF);
        txn(1, 0, 2, 0, 32'h21, 0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 1) == 0) ra = 32'($urandom_range(0, 255));
            else ra = 32'(4 * MEM_WORDS - 64 + $urandom_range(0, 127));
            txn($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                1'($urandom_range(0, 1)), ra, $urandom);
        end

        // Async reset in the middle of a split store.
        c_req = 1; c_we = 1; c_size = 1; c_unsigned = 0; c_addr = 32'h13; c_wdata = 32'h0000_1234;
        #1;
        @(posedge clk); #1;
        c_req = 0;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("arst_m_en", {31'b0, m_en}, 32'd0);
        chk("arst_m_wstrb", {28'b0, m_wstrb}, 32'd0);
        chk("arst_c_rvalid", {31'b0, c_rvalid}, 32'd0);
        if (!TRAP) refb[32'h13] = 8'h34;
        @(posedge clk); #1;

        // Both ports requesting from reset: core first, then alternate.
        c_req = 1; c_we = 0; c_size = 2; c_addr = 32'h10;
        d_req = 1; d_we = 0; d_addr = 32'h13;
        gseq.delete();
        @(negedge clk);
        rst_n = 1;
        rec_en = 1;
        #1;
        chk("first_c_ready", {31'b0, c_ready}, 32'd1);
        chk("first_d_ready", {31'b0, d_ready}, 32'd0);
        repeat (20) @(posedge clk);
        #1;
        c_req = 0; d_req = 0;
        repeat (6) @(posedge clk);
        rec_en = 0;
        chk("grant_count_ok", {31'b0, gseq.size() >= 5}, 32'd1);
        for (int i = 0; i < 5 && i < gseq.size(); i++)
            chk("grant_alt", 32'(gseq[i]), 32'(i % 2));
        chk("d_load_word4", last_d_rdata, ref_word(4));

        for (int w = 0; w < 65; w++) chk("mem_lo", dm[w], ref_word(w));
        for (int w = MEM_WORDS - 20; w < MEM_WORDS; w++) chk("mem_hi", dm[w], ref_word(w));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
